// File: rtl/block_deinterleaver_pp.sv
// Row/column block deinterleaver with two ping-pong frame banks and a 2-entry output skid.
// Optional DEINT_STATS_EN adds saturating committed-frame and framing-error counters.
//   state  | meaning
//   R_IDLE | no committed bank awaiting readout
//   R_RUN  | issuing row-major RAM reads from iss_bank
`timescale 1ns/1ps
module block_deinterleaver_pp #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DATA_W = 8
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              sof_i,
  input  logic [DATA_W-1:0] s_axis_input_tdata,
  input  logic              s_axis_input_tvalid,
  input  logic              s_axis_input_tlast,
  output logic              s_axis_input_tready,
  output logic [DATA_W-1:0] m_axis_output_tdata,
  output logic              m_axis_output_tvalid,
  output logic              m_axis_output_tlast,
  input  logic              m_axis_output_tready,
`ifdef DEINT_STATS_EN
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       err_cnt_o,
`endif
  output logic              frame_err_o
);

  localparam int FRAME_LEN = ROWS * COLS;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int COL_W     = $clog2(COLS);
  localparam int MEM_D     = 2 ** (CNT_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] ROW_STEP = CNT_W'(ROWS);

  typedef enum logic {R_IDLE, R_RUN} rd_state_t;

  logic [DATA_W-1:0] mem [MEM_D];

  logic [1:0]        full;
  logic              wr_bank;
  logic              realign_pend;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  wr_idx;
  logic              accept;
  logic              at_last;
  logic              commit;
  logic              realign_err;
  logic              tlast_err;
  logic              err_next;

  rd_state_t         state;
  logic              iss_bank;
  logic              rd_bank;
  logic [ROW_W-1:0]  r_cnt;
  logic [COL_W-1:0]  c_cnt;
  logic [CNT_W-1:0]  rd_addr;
  logic              rd_pend;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data;
  logic              sk_valid;
  logic              sk_last;
  logic [DATA_W-1:0] sk_data;
  logic              pop;
  logic              release_bank;
  logic              issue;
  logic              last_issue;
  logic [1:0]        occ_next;

  assign s_axis_input_tready = rst_n & ~full[wr_bank];
  assign accept      = s_axis_input_tvalid & s_axis_input_tready;
  // A pending realign discards the partial frame first, so a beat in that cycle starts a new frame.
  assign wr_idx      = realign_pend ? '0 : wr_cnt;
  assign at_last     = (wr_idx == LAST_IDX);
  assign commit      = accept & at_last;
  assign realign_err = realign_pend & (wr_cnt != '0);
  assign tlast_err   = accept & (at_last ^ s_axis_input_tlast);
  assign err_next    = realign_err | tlast_err;

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      full         <= '0;
      wr_bank      <= 1'b0;
      wr_cnt       <= '0;
      realign_pend <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      realign_pend <= sof_i;
      frame_err_o  <= err_next;
      if (accept)
        wr_cnt <= (at_last | s_axis_input_tlast) ? '0 : wr_idx + CNT_W'(1);
      else if (realign_pend)
        wr_cnt <= '0;
      if (commit) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (release_bank)
        full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge core_clk) begin
    if (accept)
      mem[{wr_bank, wr_idx}] <= s_axis_input_tdata;
    if (issue)
      rd_data <= mem[{iss_bank, rd_addr}];
  end

  assign pop          = m_axis_output_tvalid & m_axis_output_tready;
  assign release_bank = pop & m_axis_output_tlast;
  // Occupancy next cycle including the read in flight; a new read may issue only if it fits the skid.
  assign occ_next     = {1'b0, m_axis_output_tvalid} + {1'b0, sk_valid} + {1'b0, rd_pend}
                        - {1'b0, pop};
  assign issue        = (state == R_RUN) & (occ_next <= 2'd1);
  assign last_issue   = issue & (r_cnt == ROW_LAST) & (c_cnt == COL_LAST);

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      state                <= R_IDLE;
      iss_bank             <= 1'b0;
      rd_bank              <= 1'b0;
      r_cnt                <= '0;
      c_cnt                <= '0;
      rd_addr              <= '0;
      rd_pend              <= 1'b0;
      rd_last              <= 1'b0;
      sk_valid             <= 1'b0;
      sk_last              <= 1'b0;
      sk_data              <= '0;
      m_axis_output_tvalid <= 1'b0;
      m_axis_output_tlast  <= 1'b0;
      m_axis_output_tdata  <= '0;
    end else begin
      rd_pend <= issue;
      rd_last <= last_issue;
      if (release_bank)
        rd_bank <= ~rd_bank;

      case (state)
        R_IDLE: if (full[iss_bank]) state <= R_RUN;
        R_RUN: begin
          if (issue) begin
            if (c_cnt == COL_LAST) begin
              c_cnt <= '0;
              if (r_cnt == ROW_LAST) begin
                r_cnt    <= '0;
                rd_addr  <= '0;
                iss_bank <= ~iss_bank;
                if (!full[~iss_bank]) state <= R_IDLE;
              end else begin
                r_cnt   <= r_cnt + ROW_W'(1);
                rd_addr <= CNT_W'(r_cnt) + CNT_W'(1);
              end
            end else begin
              c_cnt   <= c_cnt + COL_W'(1);
              rd_addr <= rd_addr + ROW_STEP;
            end
          end
        end
        default: state <= R_IDLE;
      endcase

      if (!m_axis_output_tvalid || m_axis_output_tready) begin
        if (sk_valid) begin
          m_axis_output_tvalid <= 1'b1;
          m_axis_output_tdata  <= sk_data;
          m_axis_output_tlast  <= sk_last;
          sk_valid             <= rd_pend;
          sk_data              <= rd_data;
          sk_last              <= rd_last;
        end else if (rd_pend) begin
          m_axis_output_tvalid <= 1'b1;
          m_axis_output_tdata  <= rd_data;
          m_axis_output_tlast  <= rd_last;
        end else begin
          m_axis_output_tvalid <= 1'b0;
          m_axis_output_tlast  <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= rd_last;
      end
    end
  end

`ifdef DEINT_STATS_EN
  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (commit && frame_cnt_o != 16'hFFFF)
        frame_cnt_o <= frame_cnt_o + 16'd1;
      if (err_next && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_deinterleaver_pp.sv
// Scoreboard bench for block_deinterleaver_pp: stimulus pushes expected bytes, a monitor pops on output handshakes.
`timescale 1ns/1ps
module tb_block_deinterleaver_pp;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N    = ROWS * COLS;

  logic       core_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof_i = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 1'b0;
  logic       frame_err_o;
`ifdef DEINT_STATS_EN
  logic [15:0] frame_cnt_o;
  logic [15:0] err_cnt_o;
`endif

  always #5 core_clk = ~core_clk;

  block_deinterleaver_pp #(.ROWS(ROWS), .COLS(COLS), .DATA_W(8)) dut (
    .core_clk             (core_clk),
    .rst_n                (rst_n),
    .sof_i                (sof_i),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tlast   (s_tlast),
    .s_axis_input_tready  (s_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tlast  (m_tlast),
    .m_axis_output_tready (m_tready),
`ifdef DEINT_STATS_EN
    .frame_cnt_o          (frame_cnt_o),
    .err_cnt_o            (err_cnt_o),
`endif
    .frame_err_o          (frame_err_o)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         commits_n = 0;
  int         releases_n = 0;
  int         err_seen = 0;
  int         exp_err = 0;
  bit         toggle_mode = 1'b0;
  bit         hold_ready = 1'b0;
  bit         saw_in_stall = 1'b0;
  bit         prev_hold = 1'b0;
  logic [8:0] prev_out = '0;
  int         lat;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    errors++;
    $display("FAIL %s: wait bound expired, got timeout expected progress", name);
    finish_sim();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge core_clk);
      #1;
      if (hold_ready)       m_tready = 1'b0;
      else if (toggle_mode) m_tready = ~m_tready;
      else                  m_tready = 1'b1;
    end
  end

  // Monitor: sampled mid-cycle, ahead of the edge that completes each handshake.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge core_clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      if (frame_err_o) err_seen++;
      checks++;
      if (s_tready !== ((commits_n - releases_n) < 2)) begin
        errors++;
        $display("FAIL in_tready: got %0b expected %0b", s_tready, (commits_n - releases_n) < 2);
      end
      if (!s_tready) saw_in_stall = 1'b1;
      if (prev_hold) begin
        checks++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev_out) begin
          errors++;
          $display("FAIL out_stable: got v=%0b %h expected v=1 %h", m_tvalid, {m_tlast, m_tdata}, prev_out);
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_out  = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h expected no output", {m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL out_byte: got last=%0b data=%h expected last=%0b data=%h",
                     m_tlast, m_tdata, e[8], e[7:0]);
          end
        end
        if (m_tlast) releases_n++;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input bit is_commit);
    int waitc = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    @(negedge core_clk);
    while (!s_tready) begin
      waitc++;
      if (waitc > 4000) timeout_fail("input_stall");
      @(negedge core_clk);
    end
    @(posedge core_clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (is_commit) commits_n++;
  endtask

  // Input byte k = c*ROWS + r; output walks r outer, c inner.
  task automatic send_frame(input int seed, input int nbytes, input int last_idx, input bit expect_out);
    if (expect_out)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          exp_q.push_back({(r == ROWS - 1) && (c == COLS - 1), 8'((c * ROWS + r + seed) & 255)});
    for (int k = 0; k < nbytes; k++)
      send_beat(8'((k + seed) & 255), k == last_idx, k == N - 1);
  endtask

  task automatic pulse_sof();
    sof_i = 1'b1;
    @(posedge core_clk);
    #1;
    sof_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0) begin
      @(posedge core_clk);
      #1;
      n++;
      if (n > 6000) timeout_fail(name);
    end
    repeat (4) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  initial begin
    #800000;
    timeout_fail("watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge core_clk);
    #1;
    check("rst_in_tready", s_tready, 0);
    check("rst_out_tvalid", m_tvalid, 0);
    check("rst_out_tlast", m_tlast, 0);
    check("rst_out_tdata", m_tdata, 0);
    check("rst_frame_err", frame_err_o, 0);
    rst_n = 1'b1;
    @(negedge core_clk);
    check("post_rst_in_tready", s_tready, 1);
    @(posedge core_clk);
    #1;

    // T1: single frame data=k, continuous output ready, latency from commit to first tvalid
    send_frame(0, N, N - 1, 1'b1);
    lat = 0;
    while (!m_tvalid && lat < 10) begin
      @(posedge core_clk);
      #1;
      lat++;
    end
    check("t1_latency", lat, 3);
    wait_drain("t1_drain");
    check("t1_frame_err", err_seen, exp_err);

    // T2: three back-to-back frames, output ready toggling
    toggle_mode  = 1'b1;
    saw_in_stall = 1'b0;
    send_frame(1, N, N - 1, 1'b1);
    send_frame(2, N, N - 1, 1'b1);
    send_frame(3, N, N - 1, 1'b1);
    wait_drain("t2_drain");
    toggle_mode = 1'b0;
    check("t2_input_stalled", saw_in_stall, 1);
    check("t2_frame_err", err_seen, exp_err);

    // T3: sof after 100 bytes discards the partial frame
    send_frame(4, 100, -1, 1'b0);
    pulse_sof();
    exp_err++;
    send_frame(5, N, N - 1, 1'b1);
    wait_drain("t3_drain");
    check("t3_frame_err", err_seen, exp_err);

    // T4: early tlast on byte 200
    send_frame(6, 201, 200, 1'b0);
    exp_err++;
    send_frame(7, N, N - 1, 1'b1);
    wait_drain("t4_drain");
    check("t4_frame_err", err_seen, exp_err);

    // Missing tlast on byte 255: frame still committed, error flagged
    send_frame(12, N, -1, 1'b1);
    exp_err++;
    wait_drain("t7_drain");
    check("t7_frame_err", err_seen, exp_err);

    // T5: one-cycle reset mid-output
    send_frame(8, N, N - 1, 1'b1);
    n = 0;
    while (exp_q.size() > 200) begin
      @(posedge core_clk);
      #1;
      n++;
      if (n > 3000) timeout_fail("t5_partial");
    end
    hold_ready = 1'b1;
    @(posedge core_clk);
    #2;
    rst_n = 1'b0;
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    commits_n = releases_n;
    exp_q.delete();
    check("t5_tvalid_after_rst", m_tvalid, 0);
    check("t5_tlast_after_rst", m_tlast, 0);
    hold_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge core_clk);
      #1;
      check("t5_no_stale", m_tvalid, 0);
    end
    send_frame(9, N, N - 1, 1'b1);
    wait_drain("t5_drain");
    check("t5_frame_err", err_seen, exp_err);

`ifdef DEINT_STATS_EN
    // T6: counters after reset, one realign fault then one good frame
    rst_n = 1'b0;
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    commits_n = releases_n;
    check("t6_frame_cnt_rst", frame_cnt_o, 0);
    check("t6_err_cnt_rst", err_cnt_o, 0);
    send_frame(10, 100, -1, 1'b0);
    pulse_sof();
    exp_err++;
    send_frame(11, N, N - 1, 1'b1);
    wait_drain("t6_drain");
    check("t6_frame_cnt", frame_cnt_o, 1);
    check("t6_err_cnt", err_cnt_o, 1);
    check("t6_frame_err", err_seen, exp_err);
`endif

    finish_sim();
  end
endmodule
